// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: datapath width functions, the 4-Stokes
// component count and packing order, and the component-slice helper.
// Components are packed MSB-first in stokes_e order, so XX re occupies
// the most significant slice of a packed word.
package xeng_pkg;

    localparam int unsigned N_COMP = 8;

    typedef enum logic [2:0] {
        XX_RE, XX_IM, YY_RE, YY_IM, XY_RE, XY_IM, YX_RE, YX_IM
    } stokes_e;

    // Width of one serially accumulated component leaving the tap chain.
    function automatic int unsigned w_in(input int unsigned bitwidth,
                                         input int unsigned p_factor_bits,
                                         input int unsigned serial_acc_len_bits);
        return 2 * bitwidth + 1 + p_factor_bits + serial_acc_len_bits;
    endfunction

    // Full-precision width after summing 2^int_len_bits vectors.
    function automatic int unsigned w_out(input int unsigned win,
                                          input int unsigned int_len_bits);
        return win + int_len_bits;
    endfunction

    // LSB position of component idx (stokes_e order) in a packed word.
    function automatic int unsigned comp_lsb(input int unsigned idx,
                                             input int unsigned w);
        return (N_COMP - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/xeng_vector_acc_if.sv
// Stream bundle for xeng_vector_acc.
//   sync, acc_in, valid_in       : upstream word stream into the accumulator
//   dout, dout_valid, dout_last  : dump vector stream out of the accumulator
//   sync_err                     : sticky sync-misalignment flag
// master = upstream / dump consumer side, slave = the accumulator.
interface xeng_vector_acc_if #(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 160
);
    logic                 sync;
    logic [IN_WIDTH-1:0]  acc_in;
    logic                 valid_in;
    logic [OUT_WIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 dout_last;
    logic                 sync_err;

    modport master (
        output sync, acc_in, valid_in,
        input  dout, dout_valid, dout_last, sync_err
    );

    modport slave (
        input  sync, acc_in, valid_in,
        output dout, dout_valid, dout_last, sync_err
    );
endinterface

// File: rtl/xeng_acc_ram.sv
// Simple dual-port accumulation memory, 2^ADDR_BITS x WIDTH.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port, rdata registered one cycle after re
// Contents are not reset; the accumulator overwrites every word on pass 0.
module xeng_acc_ram #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned WIDTH     = 160
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_BITS) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/xeng_vector_acc.sv
// Long-term vector accumulator after the last baseline tap. Sums INT_LEN
// consecutive VECTOR_LEN-word vectors per component in full precision and
// emits one dump vector after the final pass.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of xeng_vector_acc_if (input stream, dump
//                stream, sticky sync_err)
// Pipeline: S0 registers the word and issues the RAM read, S1 aligns the
// word with the read data, S2 adds, writes back, and registers the dump.
module xeng_vector_acc
    import xeng_pkg::*;
#(
    parameter int unsigned BITWIDTH            = 4,
    parameter int unsigned P_FACTOR_BITS       = 0,
    parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
    parameter int unsigned VECTOR_LEN_BITS     = 6,
    parameter int unsigned INT_LEN_BITS        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    xeng_vector_acc_if.slave   bus
);

    localparam int unsigned W_IN      = w_in(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
    localparam int unsigned W_OUT     = w_out(W_IN, INT_LEN_BITS);
    localparam int unsigned IN_WIDTH  = N_COMP * W_IN;
    localparam int unsigned OUT_WIDTH = N_COMP * W_OUT;

    // A word's write lands two cycles after its read; four words per vector
    // keep the next read of that address clear of the pending write.
    if (VECTOR_LEN_BITS < 2) begin : g_vl_check
        $error("xeng_vector_acc: VECTOR_LEN_BITS must be >= 2");
    end
    if (INT_LEN_BITS < 1) begin : g_il_check
        $error("xeng_vector_acc: INT_LEN_BITS must be >= 1");
    end

    logic [VECTOR_LEN_BITS-1:0] addr;
    logic [INT_LEN_BITS-1:0]    pass;
    logic                       sync_err;

    logic                       s0_valid, s0_first, s0_last;
    logic [IN_WIDTH-1:0]        s0_data;
    logic [VECTOR_LEN_BITS-1:0] s0_addr;

    logic                       s1_valid, s1_first, s1_last;
    logic [IN_WIDTH-1:0]        s1_data;
    logic [VECTOR_LEN_BITS-1:0] s1_addr;

    logic [OUT_WIDTH-1:0]       ram_q;
    logic [OUT_WIDTH-1:0]       sum;
    logic [OUT_WIDTH-1:0]       dout;
    logic                       dout_valid, dout_last;

    // A word arriving with sync still uses the pre-sync counters; sync only
    // clears them for the following word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            pass     <= '0;
            sync_err <= 1'b0;
        end else begin
            if (bus.sync && (addr != '0 || pass != '0)) begin
                sync_err <= 1'b1;
            end
            if (bus.sync) begin
                addr <= '0;
                pass <= '0;
            end else if (bus.valid_in) begin
                addr <= addr + VECTOR_LEN_BITS'(1);
                if (addr == '1) begin
                    pass <= pass + INT_LEN_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_data  <= '0;
            s0_addr  <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_addr  <= '0;
        end else begin
            s0_valid <= bus.valid_in;
            if (bus.valid_in) begin
                s0_data  <= bus.acc_in;
                s0_addr  <= addr;
                s0_first <= (pass == '0);
                s0_last  <= (pass == '1);
            end
            s1_valid <= s0_valid;
            s1_data  <= s0_data;
            s1_addr  <= s0_addr;
            s1_first <= s0_first;
            s1_last  <= s0_last;
        end
    end

    xeng_acc_ram #(
        .ADDR_BITS (VECTOR_LEN_BITS),
        .WIDTH     (OUT_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (s1_valid),
        .waddr (s1_addr),
        .wdata (sum),
        .re    (s0_valid),
        .raddr (s0_addr),
        .rdata (ram_q)
    );

    // Pass 0 discards the stale RAM word instead of relying on a cleared RAM.
    for (genvar i = 0; i < N_COMP; i++) begin : g_comp
        localparam int unsigned LI = comp_lsb(i, W_IN);
        localparam int unsigned LO = comp_lsb(i, W_OUT);
        logic [W_IN-1:0]  in_c;
        logic [W_OUT-1:0] in_ext;
        logic [W_OUT-1:0] base;

        assign in_c   = s1_data[LI +: W_IN];
        assign in_ext = {{INT_LEN_BITS{in_c[W_IN-1]}}, in_c};
        assign base   = s1_first ? '0 : ram_q[LO +: W_OUT];
        assign sum[LO +: W_OUT] = base + in_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= s1_valid && s1_last;
            dout_last  <= s1_valid && s1_last && (s1_addr == '1);
            if (s1_valid && s1_last) begin
                dout <= sum;
            end
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.dout_last  = dout_last;
    assign bus.sync_err   = sync_err;

endmodule

// File: tb/tb_xeng_vector_acc.sv
// Directed bench for xeng_vector_acc. Two instances with default component
// widths (W_IN=16) and VECTOR_LEN=4: dut_a sums 2 vectors (W_OUT=17),
// dut_b sums 16 vectors (W_OUT=20).
module tb_xeng_vector_acc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xeng_vector_acc_if #(.IN_WIDTH(128), .OUT_WIDTH(136)) ia ();
    xeng_vector_acc_if #(.IN_WIDTH(128), .OUT_WIDTH(160)) ib ();

    xeng_vector_acc #(
        .BITWIDTH(4), .P_FACTOR_BITS(0), .SERIAL_ACC_LEN_BITS(7),
        .VECTOR_LEN_BITS(2), .INT_LEN_BITS(1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));

    xeng_vector_acc #(
        .BITWIDTH(4), .P_FACTOR_BITS(0), .SERIAL_ACC_LEN_BITS(7),
        .VECTOR_LEN_BITS(2), .INT_LEN_BITS(4)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int nvec = 0;
    int nbad = 0;

    logic         stim_v [0:255];
    logic         stim_s [0:255];
    logic [127:0] stim_d [0:255];
    logic         obs_v  [0:255];
    logic         obs_l  [0:255];
    logic         obs_e  [0:255];
    logic [159:0] obs_d  [0:255];
    logic         exp_v  [0:255];
    logic         exp_l  [0:255];
    logic [159:0] exp_d  [0:255];

    function automatic logic [127:0] fill_in(input logic [15:0] xx, input logic [15:0] rest);
        return {xx, {7{rest}}};
    endfunction

    function automatic logic [159:0] fill_a(input logic [16:0] xx, input logic [16:0] rest);
        return {24'b0, xx, {7{rest}}};
    endfunction

    function automatic logic [159:0] fill_b(input logic [19:0] xx, input logic [19:0] rest);
        return {xx, {7{rest}}};
    endfunction

    task automatic clear_vectors();
        for (int k = 0; k < 256; k++) begin
            stim_v[k] = 1'b0;
            stim_s[k] = 1'b0;
            stim_d[k] = '0;
            exp_v[k]  = 1'b0;
            exp_l[k]  = 1'b0;
            exp_d[k]  = '0;
        end
    endtask

    // Cycle k: sample outputs 1 time unit after edge k, then apply stim[k].
    // A word applied at cycle k shows up in obs[k+3].
    task automatic drive(input bit sel_b, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (!sel_b) begin
                obs_v[k] = ia.dout_valid;
                obs_l[k] = ia.dout_last;
                obs_e[k] = ia.sync_err;
                obs_d[k] = 160'(ia.dout);
                ia.valid_in = stim_v[k];
                ia.sync     = stim_s[k];
                ia.acc_in   = stim_d[k];
            end else begin
                obs_v[k] = ib.dout_valid;
                obs_l[k] = ib.dout_last;
                obs_e[k] = ib.sync_err;
                obs_d[k] = ib.dout;
                ib.valid_in = stim_v[k];
                ib.sync     = stim_s[k];
                ib.acc_in   = stim_d[k];
            end
        end
    endtask

    task automatic test_reset();
        ia.sync = 1'b0; ia.valid_in = 1'b0; ia.acc_in = '0;
        ib.sync = 1'b0; ib.valid_in = 1'b0; ib.acc_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (ia.dout_valid !== 1'b0 || ia.dout_last !== 1'b0 || ia.sync_err !== 1'b0) begin
            nbad++;
            $display("FAIL reset_flags_a: got v=%b l=%b e=%b want 0 0 0", ia.dout_valid, ia.dout_last, ia.sync_err);
        end
        nvec++;
        if (ia.dout !== '0) begin
            nbad++;
            $display("FAIL reset_dout_a: got %h want 0", ia.dout);
        end
        nvec++;
        if (ib.dout_valid !== 1'b0 || ib.dout_last !== 1'b0 || ib.sync_err !== 1'b0 || ib.dout !== '0) begin
            nbad++;
            $display("FAIL reset_b: got v=%b l=%b e=%b d=%h want all 0", ib.dout_valid, ib.dout_last, ib.sync_err, ib.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int pulses;
        clear_vectors();
        stim_s[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            stim_v[k] = 1'b1;
            stim_d[k] = fill_in(16'd1, 16'd1);
        end
        for (int k = 8; k <= 11; k++) begin
            exp_v[k] = 1'b1;
            exp_d[k] = fill_a(17'd2, 17'd2);
        end
        exp_l[11] = 1'b1;
        drive(1'b0, 14);
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            if (obs_v[k] === 1'b1) pulses++;
            nvec++;
            if (obs_v[k] !== exp_v[k] || obs_l[k] !== exp_l[k]) begin
                nbad++;
                $display("FAIL basic_valid cyc %0d: got v=%b l=%b want v=%b l=%b", k, obs_v[k], obs_l[k], exp_v[k], exp_l[k]);
            end
            if (exp_v[k]) begin
                nvec++;
                if (obs_d[k] !== exp_d[k]) begin
                    nbad++;
                    $display("FAIL basic_dout cyc %0d: got %h want %h", k, obs_d[k], exp_d[k]);
                end
            end
        end
        nvec++;
        if (pulses != 4) begin
            nbad++;
            $display("FAIL basic_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_gapped();
        clear_vectors();
        stim_s[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            stim_v[1 + 2 * j] = 1'b1;
            stim_d[1 + 2 * j] = fill_in(16'd1, 16'd1);
            if (j >= 4) begin
                exp_v[4 + 2 * j] = 1'b1;
                exp_d[4 + 2 * j] = fill_a(17'd2, 17'd2);
            end
        end
        exp_l[18] = 1'b1;
        drive(1'b0, 22);
        for (int k = 0; k < 22; k++) begin
            nvec++;
            if (obs_v[k] !== exp_v[k] || obs_l[k] !== exp_l[k]) begin
                nbad++;
                $display("FAIL gapped_valid cyc %0d: got v=%b l=%b want v=%b l=%b", k, obs_v[k], obs_l[k], exp_v[k], exp_l[k]);
            end
            if (exp_v[k]) begin
                nvec++;
                if (obs_d[k] !== exp_d[k]) begin
                    nbad++;
                    $display("FAIL gapped_dout cyc %0d: got %h want %h", k, obs_d[k], exp_d[k]);
                end
            end
        end
    endtask

    // -32768 * 16 = -524288 (20'h80000); 32767 * 16 = 524272 (20'h7FFF0).
    task automatic test_sign();
        clear_vectors();
        stim_s[0] = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            stim_v[k] = 1'b1;
            stim_d[k] = fill_in(16'h8000, 16'h7FFF);
        end
        for (int k = 64; k <= 67; k++) begin
            exp_v[k] = 1'b1;
            exp_d[k] = fill_b(20'h80000, 20'h7FFF0);
        end
        exp_l[67] = 1'b1;
        drive(1'b1, 70);
        for (int k = 0; k < 70; k++) begin
            nvec++;
            if (obs_v[k] !== exp_v[k] || obs_l[k] !== exp_l[k]) begin
                nbad++;
                $display("FAIL sign_valid cyc %0d: got v=%b l=%b want v=%b l=%b", k, obs_v[k], obs_l[k], exp_v[k], exp_l[k]);
            end
            if (exp_v[k]) begin
                nvec++;
                if (obs_d[k] !== exp_d[k]) begin
                    nbad++;
                    $display("FAIL sign_dout cyc %0d: got %h want %h", k, obs_d[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_sync_err();
        nvec++;
        if (ia.sync_err !== 1'b0) begin
            nbad++;
            $display("FAIL sync_err_pre: got %b want 0", ia.sync_err);
        end
        clear_vectors();
        stim_s[0] = 1'b1;
        stim_v[1] = 1'b1; stim_d[1] = fill_in(16'd9, 16'd9);
        stim_v[2] = 1'b1; stim_d[2] = fill_in(16'd9, 16'd9);
        stim_s[3] = 1'b1;
        for (int k = 4; k <= 11; k++) begin
            stim_v[k] = 1'b1;
            stim_d[k] = fill_in(16'd3, 16'd3);
        end
        for (int k = 11; k <= 14; k++) begin
            exp_v[k] = 1'b1;
            exp_d[k] = fill_a(17'd6, 17'd6);
        end
        exp_l[14] = 1'b1;
        drive(1'b0, 18);
        for (int k = 0; k < 18; k++) begin
            nvec++;
            if (obs_e[k] !== (k >= 4)) begin
                nbad++;
                $display("FAIL sync_err_flag cyc %0d: got %b want %b", k, obs_e[k], (k >= 4));
            end
            nvec++;
            if (obs_v[k] !== exp_v[k] || obs_l[k] !== exp_l[k]) begin
                nbad++;
                $display("FAIL resync_valid cyc %0d: got v=%b l=%b want v=%b l=%b", k, obs_v[k], obs_l[k], exp_v[k], exp_l[k]);
            end
            if (exp_v[k]) begin
                nvec++;
                if (obs_d[k] !== exp_d[k]) begin
                    nbad++;
                    $display("FAIL resync_dout cyc %0d: got %h want %h", k, obs_d[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        clear_vectors();
        stim_s[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            stim_v[k] = 1'b1;
            stim_d[k] = fill_in(16'd5, 16'd5);
        end
        exp_v[8] = 1'b1;
        exp_d[8] = fill_a(17'd10, 17'd10);
        drive(1'b0, 9);
        nvec++;
        if (obs_v[8] !== 1'b1 || obs_d[8] !== exp_d[8]) begin
            nbad++;
            $display("FAIL prereset_dout: got v=%b d=%h want v=1 d=%h", obs_v[8], obs_d[8], exp_d[8]);
        end
        // Mid-cycle, while pass-1 words are still in flight.
        #3;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (ia.dout_valid !== 1'b0 || ia.dout_last !== 1'b0 || ia.sync_err !== 1'b0 || ia.dout !== '0) begin
            nbad++;
            $display("FAIL async_reset_outputs: got v=%b l=%b e=%b d=%h want all 0", ia.dout_valid, ia.dout_last, ia.sync_err, ia.dout);
        end
        ia.valid_in = 1'b0;
        ia.sync     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_vectors();
        drive(1'b0, 6);
        for (int k = 0; k < 6; k++) begin
            nvec++;
            if (obs_v[k] !== 1'b0) begin
                nbad++;
                $display("FAIL inflight_dropped cyc %0d: got v=%b want 0", k, obs_v[k]);
            end
        end
        clear_vectors();
        for (int k = 0; k < 8; k++) begin
            stim_v[k] = 1'b1;
            stim_d[k] = fill_in(16'd7, 16'd7);
        end
        for (int k = 7; k <= 10; k++) begin
            exp_v[k] = 1'b1;
            exp_d[k] = fill_a(17'd14, 17'd14);
        end
        exp_l[10] = 1'b1;
        drive(1'b0, 13);
        for (int k = 0; k < 13; k++) begin
            nvec++;
            if (obs_v[k] !== exp_v[k] || obs_l[k] !== exp_l[k]) begin
                nbad++;
                $display("FAIL postreset_valid cyc %0d: got v=%b l=%b want v=%b l=%b", k, obs_v[k], obs_l[k], exp_v[k], exp_l[k]);
            end
            if (exp_v[k]) begin
                nvec++;
                if (obs_d[k] !== exp_d[k]) begin
                    nbad++;
                    $display("FAIL postreset_dout cyc %0d: got %h want %h", k, obs_d[k], exp_d[k]);
                end
            end
        end
    endtask

    // 3 back-to-back dumps of 16 passes x 4 words, summed in a plain model.
    task automatic test_back_to_back();
        int acc [0:3][0:7];
        int p, a, k, pulses;
        logic signed [15:0] x;
        logic [127:0] d;
        logic [159:0] e;
        clear_vectors();
        stim_s[0] = 1'b1;
        for (int j = 0; j < 192; j++) begin
            p = (j / 4) % 16;
            a = j % 4;
            k = 1 + j;
            d = '0;
            for (int c = 0; c < 8; c++) begin
                x = 16'($urandom);
                d[(7 - c) * 16 +: 16] = x;
                acc[a][c] = (p == 0) ? int'(x) : acc[a][c] + int'(x);
            end
            stim_v[k] = 1'b1;
            stim_d[k] = d;
            if (p == 15) begin
                e = '0;
                for (int c = 0; c < 8; c++) begin
                    e[(7 - c) * 20 +: 20] = 20'(acc[a][c]);
                end
                exp_v[k + 3] = 1'b1;
                exp_l[k + 3] = (a == 3);
                exp_d[k + 3] = e;
            end
        end
        drive(1'b1, 198);
        pulses = 0;
        for (int n = 0; n < 198; n++) begin
            if (obs_v[n] === 1'b1) pulses++;
            nvec++;
            if (obs_v[n] !== exp_v[n] || obs_l[n] !== exp_l[n]) begin
                nbad++;
                $display("FAIL b2b_valid cyc %0d: got v=%b l=%b want v=%b l=%b", n, obs_v[n], obs_l[n], exp_v[n], exp_l[n]);
            end
            if (exp_v[n]) begin
                nvec++;
                if (obs_d[n] !== exp_d[n]) begin
                    nbad++;
                    $display("FAIL b2b_dout cyc %0d: got %h want %h", n, obs_d[n], exp_d[n]);
                end
            end
        end
        nvec++;
        if (pulses != 12) begin
            nbad++;
            $display("FAIL b2b_pulses: got %0d want 12", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_sign();
        test_sync_err();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
